// File: rtl/reg_writeback_ctrl_pkg.sv
// Shared register-file constants and helpers for the write-back controller
// and its load queue.
package reg_writeback_ctrl_pkg;

  localparam int unsigned REG_ADDR_W     = 5;
  localparam int unsigned NUM_REGS       = 32;
  localparam int unsigned DATA_WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    WB_NONE,
    WB_ALU,
    WB_LQ
  } wb_src_e;

  // x0 is hard-wired, so it never gets a scoreboard bit.
  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] rd);
    logic [NUM_REGS-1:0] v;
    v = '0;
    if (rd != '0) v[rd] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/reg_writeback_ctrl_wb_fifo.sv
// Circular load queue: separate read/write pointers, occupancy count
// distinguishes full from empty.
module wb_fifo #(
  parameter int unsigned WIDTH = 37,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full queue can still take a push.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/reg_writeback_ctrl.sv
// Single-port register write-back arbiter between the ALU and a load queue,
// with a pending-write scoreboard.
module reg_writeback_ctrl
  import reg_writeback_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned LQ_DEPTH   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [DATA_WIDTH-1:0] alu_data,
  output logic                  alu_ready,
  input  logic                  ld_valid,
  input  logic [REG_ADDR_W-1:0] ld_rd,
  input  logic [DATA_WIDTH-1:0] ld_data,
  output logic                  ld_ready,
  output logic                  wr_en,
  output logic [REG_ADDR_W-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic [NUM_REGS-1:0]   busy
);

  localparam int unsigned ENTRY_W = REG_ADDR_W + DATA_WIDTH;

  logic                  lq_push;
  logic                  lq_pop;
  logic                  lq_full;
  logic                  lq_empty;
  logic [ENTRY_W-1:0]    lq_din;
  logic [ENTRY_W-1:0]    lq_dout;
  wb_src_e               win_src;
  logic [REG_ADDR_W-1:0] win_rd;
  logic [DATA_WIDTH-1:0] win_data;
  logic [NUM_REGS-1:0]   set_vec;
  logic [NUM_REGS-1:0]   clr_vec;

  assign ld_ready = !lq_full;
  assign alu_ready = !lq_full;
  assign lq_push  = ld_valid && ld_ready;
  assign lq_din   = {ld_rd, ld_data};

  wb_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (LQ_DEPTH)
  ) u_lq (
    .clk   (clk),
    .reset (reset),
    .push  (lq_push),
    .pop   (lq_pop),
    .din   (lq_din),
    .dout  (lq_dout),
    .full  (lq_full),
    .empty (lq_empty)
  );

  // A full queue preempts the ALU so loads cannot starve.
  always_comb begin
    win_src = WB_NONE;
    if (lq_full)          win_src = WB_LQ;
    else if (alu_valid)   win_src = WB_ALU;
    else if (!lq_empty)   win_src = WB_LQ;
  end

  assign lq_pop = (win_src == WB_LQ);

  always_comb begin
    win_rd   = '0;
    win_data = '0;
    case (win_src)
      WB_ALU: begin
        win_rd   = alu_rd;
        win_data = alu_data;
      end
      WB_LQ: begin
        win_rd   = lq_dout[ENTRY_W-1 -: REG_ADDR_W];
        win_data = lq_dout[DATA_WIDTH-1:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= (win_src != WB_NONE) && (win_rd != '0);
      if ((win_src != WB_NONE) && (win_rd != '0)) begin
        wr_addr <= win_rd;
        wr_data <= win_data;
      end
    end
  end

  assign set_vec = issue_valid ? reg_onehot(issue_rd) : '0;
  assign clr_vec = wr_en ? reg_onehot(wr_addr) : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) busy <= '0;
    else       busy <= (busy & ~clr_vec) | set_vec;
  end

endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// Directed, table-driven bench for reg_writeback_ctrl plus a mid-operation
// reset sequence.
module tb_reg_writeback_ctrl;

  logic        clk;
  logic        reset;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        ld_valid;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        ld_ready;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [31:0] busy;

  int checks = 0;
  int errors = 0;

  reg_writeback_ctrl #(
    .DATA_WIDTH (32),
    .LQ_DEPTH   (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .alu_valid   (alu_valid),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .alu_ready   (alu_ready),
    .ld_valid    (ld_valid),
    .ld_rd       (ld_rd),
    .ld_data     (ld_data),
    .ld_ready    (ld_ready),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [4:0]  ird;
    logic        av;
    logic [4:0]  ard;
    logic [31:0] adata;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ldata;
    logic        e_ar;
    logic        e_lr;
    logic        e_we;
    logic [4:0]  e_wa;
    logic [31:0] e_wd;
    logic [31:0] e_busy;
  } vec_t;

  vec_t vecs[19];

  function automatic vec_t mk(input logic iv, input logic [4:0] ird,
                              input logic av, input logic [4:0] ard, input logic [31:0] adata,
                              input logic lv, input logic [4:0] lrd, input logic [31:0] ldata,
                              input logic e_ar, input logic e_lr,
                              input logic e_we, input logic [4:0] e_wa, input logic [31:0] e_wd,
                              input logic [31:0] e_busy);
    vec_t v;
    v.iv = iv; v.ird = ird; v.av = av; v.ard = ard; v.adata = adata;
    v.lv = lv; v.lrd = lrd; v.ldata = ldata;
    v.e_ar = e_ar; v.e_lr = e_lr; v.e_we = e_we; v.e_wa = e_wa; v.e_wd = e_wd;
    v.e_busy = e_busy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [4:0] ird,
                       input logic av, input logic [4:0] ard, input logic [31:0] adata,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ldata);
    issue_valid = iv; issue_rd = ird;
    alu_valid = av; alu_rd = ard; alu_data = adata;
    ld_valid = lv; ld_rd = lrd; ld_data = ldata;
  endtask

  initial begin
    //                iv ird   av ard  adata         lv lrd  ldata     ar lr  we wa  wd            busy
    vecs[0]  = mk(0, 5'd0, 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0,     1, 1,  1, 5'd5, 32'hDEADBEEF, 32'h0);
    vecs[1]  = mk(0, 5'd0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,     1, 1,  0, 5'd5, 32'hDEADBEEF, 32'h0);
    vecs[2]  = mk(1, 5'd7, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,     1, 1,  0, 5'd5, 32'hDEADBEEF, 32'h80);
    vecs[3]  = mk(1, 5'd9, 1, 5'd7, 32'h77,       0, 5'd0, 32'h0,     1, 1,  1, 5'd7, 32'h77,       32'h280);
    vecs[4]  = mk(1, 5'd7, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,     1, 1,  0, 5'd7, 32'h77,       32'h280);
    vecs[5]  = mk(0, 5'd0, 1, 5'd9, 32'h99,       0, 5'd0, 32'h0,     1, 1,  1, 5'd9, 32'h99,       32'h280);
    vecs[6]  = mk(0, 5'd0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,     1, 1,  0, 5'd9, 32'h99,       32'h80);
    vecs[7]  = mk(1, 5'd0, 1, 5'd0, 32'h55,       0, 5'd0, 32'h0,     1, 1,  0, 5'd9, 32'h99,       32'h80);
    vecs[8]  = mk(0, 5'd0, 1, 5'd3, 32'h11,       1, 5'd4, 32'h22,    1, 1,  1, 5'd3, 32'h11,       32'h80);
    vecs[9]  = mk(0, 5'd0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,     1, 1,  1, 5'd4, 32'h22,       32'h80);
    vecs[10] = mk(0, 5'd0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,     1, 1,  0, 5'd4, 32'h22,       32'h80);
    vecs[11] = mk(0, 5'd0, 1, 5'd1, 32'hA1,       1, 5'd10, 32'hB0,   1, 1,  1, 5'd1, 32'hA1,       32'h80);
    vecs[12] = mk(0, 5'd0, 1, 5'd1, 32'hA2,       1, 5'd11, 32'hB1,   1, 1,  1, 5'd1, 32'hA2,       32'h80);
    vecs[13] = mk(0, 5'd0, 1, 5'd1, 32'hA3,       1, 5'd12, 32'hB2,   0, 0,  1, 5'd10, 32'hB0,      32'h80);
    vecs[14] = mk(0, 5'd0, 1, 5'd1, 32'hA3,       0, 5'd0, 32'h0,     1, 1,  1, 5'd1, 32'hA3,       32'h80);
    vecs[15] = mk(0, 5'd0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,     1, 1,  1, 5'd11, 32'hB1,      32'h80);
    vecs[16] = mk(0, 5'd0, 0, 5'd0, 32'h0,        1, 5'd0, 32'h5A,    1, 1,  0, 5'd11, 32'hB1,      32'h80);
    vecs[17] = mk(0, 5'd0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,     1, 1,  0, 5'd11, 32'hB1,      32'h80);
    vecs[18] = mk(0, 5'd0, 1, 5'd2, 32'h22,       0, 5'd0, 32'h0,     1, 1,  1, 5'd2, 32'h22,       32'h80);

    reset = 1'b1;
    drive(0, 5'd0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    #1;
    chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
    chk("rst_wr_addr", {27'd0, wr_addr}, 32'd0);
    chk("rst_wr_data", wr_data, 32'd0);
    chk("rst_busy", busy, 32'd0);
    chk("rst_alu_ready", {31'd0, alu_ready}, 32'd1);
    chk("rst_ld_ready", {31'd0, ld_ready}, 32'd1);
    #11 reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].iv, vecs[i].ird, vecs[i].av, vecs[i].ard, vecs[i].adata,
            vecs[i].lv, vecs[i].lrd, vecs[i].ldata);
      #2;
      chk($sformatf("v%0d_alu_ready", i), {31'd0, alu_ready}, {31'd0, vecs[i].e_ar});
      chk($sformatf("v%0d_ld_ready", i), {31'd0, ld_ready}, {31'd0, vecs[i].e_lr});
      @(posedge clk); #1;
      chk($sformatf("v%0d_wr_en", i), {31'd0, wr_en}, {31'd0, vecs[i].e_we});
      chk($sformatf("v%0d_wr_addr", i), {27'd0, wr_addr}, {27'd0, vecs[i].e_wa});
      chk($sformatf("v%0d_wr_data", i), wr_data, vecs[i].e_wd);
      chk($sformatf("v%0d_busy", i), busy, vecs[i].e_busy);
    end

    // Mid-operation reset: two loads queued behind a busy ALU, busy = 0x80.
    drive(0, 5'd0, 1, 5'd2, 32'h23, 1, 5'd20, 32'hC0);
    @(posedge clk); #1;
    drive(0, 5'd0, 1, 5'd2, 32'h24, 1, 5'd21, 32'hC1);
    @(posedge clk); #1;
    chk("pre_rst_full", {31'd0, ld_ready}, 32'd0);
    chk("pre_rst_busy", busy, 32'h80);
    drive(0, 5'd0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_wr_en", {31'd0, wr_en}, 32'd0);
    chk("async_rst_wr_addr", {27'd0, wr_addr}, 32'd0);
    chk("async_rst_wr_data", wr_data, 32'd0);
    chk("async_rst_busy", busy, 32'd0);
    chk("async_rst_ld_ready", {31'd0, ld_ready}, 32'd1);
    chk("async_rst_alu_ready", {31'd0, alu_ready}, 32'd1);
    @(posedge clk); #3;
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk($sformatf("post_rst_idle%0d_wr_en", c), {31'd0, wr_en}, 32'd0);
      chk($sformatf("post_rst_idle%0d_busy", c), busy, 32'd0);
    end
    drive(0, 5'd0, 1, 5'd6, 32'h66, 0, 5'd0, 32'h0);
    @(posedge clk); #1;
    drive(0, 5'd0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    chk("post_rst_first_wr_en", {31'd0, wr_en}, 32'd1);
    chk("post_rst_first_wr_addr", {27'd0, wr_addr}, 32'd6);
    chk("post_rst_first_wr_data", wr_data, 32'h66);
    @(posedge clk); #1;
    chk("post_rst_drain_wr_en", {31'd0, wr_en}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
